// File: rtl/pixel_memory_arbiter.sv
// Round-robin arbiter that shares one pixel memory port between the image
// loader (A) and the image processor (B). Tenures are capped at MAX_BURST
// accesses while the other side waits, and each tenure ends with an RD_LAT
// cycle turnaround so outstanding reads return on the side that issued them.
//
// Handshake: a requester raises req_x with we_x/addr_x/wdata_x and holds it.
// An access is taken in every cycle where req_x and gnt_x are both high. gnt_x
// only reflects ownership, so a requester that is not granted is simply ignored.
// Read data comes back on rvalid_x/rdata_x exactly RD_LAT cycles after the
// accepted read. There is no back-pressure on read data.
module pixel_memory_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_select,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(RD_LAT - 1);

  state_t          state, state_nxt;
  logic            last_owner, last_owner_nxt;   // 0 = A, 1 = B
  logic            select_nxt;
  logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
  logic [TW-1:0]   turn_cnt, turn_cnt_nxt;
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_owner;

  logic acc_a, acc_b, acc;
  logic acc_we;
  logic own_req, oth_req;
  logic pick_b;

  assign gnt_a     = (state == OWN_A);
  assign gnt_b     = (state == OWN_B);
  assign acc_a     = gnt_a & req_a;
  assign acc_b     = gnt_b & req_b;
  assign acc       = acc_a | acc_b;
  assign acc_we    = acc_b ? we_b : we_a;
  assign own_req   = (state == OWN_B) ? req_b : req_a;
  assign oth_req   = (state == OWN_B) ? req_a : req_b;
  // With both requesting, the side that did not own last time wins.
  assign pick_b    = req_b & (~req_a | ~last_owner);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Memory port mux: driven only during an accepted access, zero otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (acc_a) begin
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
      mem_wren  = we_a;
    end else if (acc_b) begin
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
      mem_wren  = we_b;
    end
  end

  // Next-state logic for the ownership FSM and its counters.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    select_nxt     = mem_select;
    burst_cnt_nxt  = burst_cnt;
    turn_cnt_nxt   = turn_cnt;
    case (state)
      IDLE: begin
        if (req_a | req_b) begin
          state_nxt      = pick_b ? OWN_B : OWN_A;
          last_owner_nxt = pick_b;
          select_nxt     = pick_b;
          burst_cnt_nxt  = '0;
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req) begin
          state_nxt    = TURN;
          turn_cnt_nxt = '0;
        end else if (burst_cnt == BURST_LAST) begin
          burst_cnt_nxt = '0;
          if (oth_req) begin
            state_nxt    = TURN;
            turn_cnt_nxt = '0;
          end
        end else begin
          burst_cnt_nxt = burst_cnt + BW'(1);
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          state_nxt = IDLE;
        end else begin
          turn_cnt_nxt = turn_cnt + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and counter registers. mem_select only changes on a new grant,
  // so it holds through TURN while reads drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      mem_select <= 1'b0;
      burst_cnt  <= '0;
      turn_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      mem_select <= select_nxt;
      burst_cnt  <= burst_cnt_nxt;
      turn_cnt   <= turn_cnt_nxt;
    end
  end

  // Read-tag pipeline: one stage per cycle of memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      pipe_valid[0] <= acc & ~acc_we;
      pipe_owner[0] <= acc_b;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
    end
  end

  assign rvalid_a = pipe_valid[RD_LAT-1] & ~pipe_owner[RD_LAT-1];
  assign rvalid_b = pipe_valid[RD_LAT-1] &  pipe_owner[RD_LAT-1];
  assign rdata_a  = rvalid_a ? mem_q : '0;
  assign rdata_b  = rvalid_b ? mem_q : '0;

endmodule
